cmp_share_arbiter: RTL and testbench

- Shares one 16-bit magnitude comparator (gt/lt/eq outputs) among NUM_REQ requesters using a round-robin req/grant handshake.
- Latches the granted requester's operands and drives them to the comparator instance.
- Registers the comparator's gt/lt/eq result and returns it with a one-cycle done pulse tagged with the requester index.
- Sits between client blocks and a single comparator instance in the datapath.

---
 rtl/cmp_share_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one external 16-bit magnitude comparator among NUM_REQ clients.
// Define CMP_SHARE_ARB_CHECK_EN to build the sticky one-hot consistency check driving err.
module cmp_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int ID_W    = 2
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   a_in,
   input  logic [NUM_REQ*DATA_W-1:0]   b_in,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        busy,
   output logic [DATA_W-1:0]           cmp_a,
   output logic [DATA_W-1:0]           cmp_b,
   input  logic                        cmp_gt,
   input  logic                        cmp_lt,
   input  logic                        cmp_eq,
   output logic                        done,
   output logic [ID_W-1:0]             done_id,
   output logic                        gt,
   output logic                        lt,
   output logic                        eq,
   output logic                        err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL   = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t                 state_r, state_s;
   logic [NUM_REQ-1:0]     grant_r, grant_s;
   logic                   busy_r, busy_s;
   logic [DATA_W-1:0]      cmp_a_r, cmp_a_s;
   logic [DATA_W-1:0]      cmp_b_r, cmp_b_s;
   logic                   done_r, done_s;
   logic [ID_W-1:0]        done_id_r, done_id_s;
   logic                   gt_r, gt_s;
   logic                   lt_r, lt_s;
   logic                   eq_r, eq_s;
   logic [ID_W-1:0]        last_r, last_s;
   logic                   found_s;
   logic [ID_W-1:0]        sel_s;
   int                     cand_v;

   function automatic logic req_bit(input logic [NUM_REQ-1:0] v, input int pos);
      return ((v >> pos) & NUM_REQ'(1'b1)) != {NUM_REQ{1'b0}};
   endfunction

   function automatic logic [DATA_W-1:0] slice_of(input logic [NUM_REQ*DATA_W-1:0] v,
                                                  input logic [ID_W-1:0] idx);
      return DATA_W'(v >> (int'(idx) * DATA_W));
   endfunction

`ifdef CMP_SHARE_ARB_CHECK_EN
   logic err_r, err_s;

   function automatic logic is_onehot3(input logic [2:0] v);
      case (v)
         3'b001, 3'b010, 3'b100: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction
`endif

   // Rotating search from last+1; descending loop so the nearest candidate wins.
   always_comb begin
      found_s = 1'b0;
      sel_s   = last_r;
      cand_v  = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand_v  = (int'(last_r) + 1 + i) % NUM_REQ;
         found_s = found_s | req_bit(req, cand_v);
         sel_s   = req_bit(req, cand_v) ? ID_W'(cand_v) : sel_s;
      end
   end

   // Next-state and next-output computation for the capture/evaluate/result sequence.
   always_comb begin
      state_s   = state_r;
      grant_s   = grant_r;
      cmp_a_s   = cmp_a_r;
      cmp_b_s   = cmp_b_r;
      done_s    = done_r;
      done_id_s = done_id_r;
      gt_s      = gt_r;
      lt_s      = lt_r;
      eq_s      = eq_r;
      last_s    = last_r;
`ifdef CMP_SHARE_ARB_CHECK_EN
      err_s     = err_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               cmp_a_s   = slice_of(a_in, sel_s);
               cmp_b_s   = slice_of(b_in, sel_s);
               grant_s   = NUM_REQ'(1'b1) << sel_s;
               last_s    = sel_s;
               done_id_s = sel_s;
               state_s   = ST_EVAL;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_EVAL: begin
            gt_s    = cmp_gt;
            lt_s    = cmp_lt;
            eq_s    = cmp_eq;
            grant_s = {NUM_REQ{1'b0}};
            done_s  = 1'b1;
            state_s = ST_RESULT;
`ifdef CMP_SHARE_ARB_CHECK_EN
            err_s   = err_r | ~is_onehot3({cmp_gt, cmp_lt, cmp_eq});
`endif
         end
         ST_RESULT: begin
            done_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            grant_s = {NUM_REQ{1'b0}};
            done_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Output and pointer registers; pointer restarts so requester 0 wins first.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         grant_r   <= {NUM_REQ{1'b0}};
         busy_r    <= 1'b0;
         cmp_a_r   <= {DATA_W{1'b0}};
         cmp_b_r   <= {DATA_W{1'b0}};
         done_r    <= 1'b0;
         done_id_r <= {ID_W{1'b0}};
         gt_r      <= 1'b0;
         lt_r      <= 1'b0;
         eq_r      <= 1'b0;
         last_r    <= ID_W'(NUM_REQ - 1);
      end else begin
         grant_r   <= grant_s;
         busy_r    <= busy_s;
         cmp_a_r   <= cmp_a_s;
         cmp_b_r   <= cmp_b_s;
         done_r    <= done_s;
         done_id_r <= done_id_s;
         gt_r      <= gt_s;
         lt_r      <= lt_s;
         eq_r      <= eq_s;
         last_r    <= last_s;
      end
   end

`ifdef CMP_SHARE_ARB_CHECK_EN
   // Sticky consistency flag, cleared only by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_s;
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   assign grant   = grant_r;
   assign busy    = busy_r;
   assign cmp_a   = cmp_a_r;
   assign cmp_b   = cmp_b_r;
   assign done    = done_r;
   assign done_id = done_id_r;
   assign gt      = gt_r;
   assign lt      = lt_r;
   assign eq      = eq_r;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: transaction-level model checked every cycle plus directed literals.
// Honours CMP_SHARE_ARB_CHECK_EN the same way as the design.
module tb_cmp_share_arbiter;
   localparam int N = 4;
   localparam int W = 16;
`ifdef CMP_SHARE_ARB_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic           clk;
   logic           n_rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in, b_in;
   logic [N-1:0]   grant;
   logic           busy, done, gt, lt, eq, err;
   logic [W-1:0]   cmp_a, cmp_b;
   logic           cmp_gt, cmp_lt, cmp_eq;
   logic [1:0]     done_id;
   logic           bad;

   int errors = 0;
   int checks = 0;

   cmp_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2)) dut (
      .clk(clk), .n_rst(n_rst), .req(req), .a_in(a_in), .b_in(b_in),
      .grant(grant), .busy(busy), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
      .done(done), .done_id(done_id), .gt(gt), .lt(lt), .eq(eq), .err(err)
   );

   // Ideal unsigned comparator, with an injectable inconsistent answer.
   assign cmp_gt = bad ? 1'b1 : (cmp_a > cmp_b);
   assign cmp_lt = bad ? 1'b0 : (cmp_a < cmp_b);
   assign cmp_eq = bad ? 1'b1 : (cmp_a == cmp_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: remembers the edge of the last capture and derives outputs from it.
   int           cyc = 0;
   int           cap = -100;
   int           last_m = N - 1;
   logic [N-1:0] e_grant = '0;
   logic         e_busy = 1'b0, e_done = 1'b0, e_gt = 1'b0, e_lt = 1'b0, e_eq = 1'b0, e_err = 1'b0;
   logic [1:0]   e_id = 2'd0;
   logic [W-1:0] e_a = '0, e_b = '0;
   logic [2:0]   res;
   int           sel;
   logic         found;

   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) begin
            cyc = 0; cap = -100; last_m = N - 1;
            e_grant = '0; e_busy = 1'b0; e_done = 1'b0; e_id = 2'd0;
            e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0; e_a = '0; e_b = '0; e_err = 1'b0;
         end else begin
            cyc++;
            if (cyc == cap + 1) begin
               res = bad ? 3'b101 : {e_a > e_b, e_a < e_b, e_a == e_b};
               {e_gt, e_lt, e_eq} = res;
`ifdef CMP_SHARE_ARB_CHECK_EN
               if ($countones(res) != 1) e_err = 1'b1;
`endif
            end
            if (cyc >= cap + 3 && req != '0) begin
               found = 1'b0;
               sel = 0;
               for (int d = 1; d <= N; d++) begin
                  if (!found && req[(last_m + d) % N]) begin
                     found = 1'b1;
                     sel = (last_m + d) % N;
                  end
               end
               cap = cyc; last_m = sel; e_id = 2'(sel);
               e_a = a_in[sel*W +: W];
               e_b = b_in[sel*W +: W];
            end
            e_grant = (cyc == cap) ? N'(1) << last_m : '0;
            e_busy  = (cyc == cap) || (cyc == cap + 1);
            e_done  = (cyc == cap + 1);
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("m_grant", grant, e_grant);
         chk("m_busy", busy, e_busy);
         chk("m_done", done, e_done);
         chk("m_done_id", done_id, e_id);
         chk("m_result", {gt, lt, eq}, {e_gt, e_lt, e_eq});
         chk("m_cmp_a", cmp_a, e_a);
         chk("m_cmp_b", cmp_b, e_b);
         chk("m_err", err, e_err);
      end
   end

   task automatic rst_pulse();
      @(negedge clk);
      #2 n_rst = 1'b0;
      @(negedge clk);
      #2 n_rst = 1'b1;
   endtask

   task automatic do_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fault, input logic [2:0] exp_res);
      int n;
      a_in[idx*W +: W] = a;
      b_in[idx*W +: W] = b;
      req = N'(1) << idx;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < 10);
      chk("t_grant", grant, N'(1) << idx);
      bad = fault;
      req = '0;
      @(negedge clk);
      bad = 1'b0;
      chk("t_done", done, 1'b1);
      chk("t_done_id", done_id, idx);
      chk("t_result", {gt, lt, eq}, exp_res);
      @(negedge clk);
      chk("t_done_clr", done, 1'b0);
   endtask

   logic [N-1:0] gs [5];
   logic [1:0]   ds [5];
   logic         eqs [5];
   int           dc [5];
   logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   int           ng, nd;

   initial begin
      n_rst = 1'b0; req = '0; a_in = '0; b_in = '0; bad = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_grant", grant, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cmp_a", cmp_a, 16'h0000);
      #2 n_rst = 1'b1;

      do_one(0, 16'h1234, 16'h1233, 1'b0, 3'b100);

      // All requesters active with equal operands: strict rotation.
      rst_pulse();
      for (int i = 0; i < N; i++) begin
         a_in[i*W +: W] = 16'h0C00 + 16'(i);
         b_in[i*W +: W] = 16'h0C00 + 16'(i);
      end
      for (int k = 0; k < 5; k++) begin
         gs[k] = '0; ds[k] = 2'd0; eqs[k] = 1'b0; dc[k] = 0;
      end
      req = 4'hF; ng = 0; nd = 0;
      for (int c = 0; c < 40 && nd < 5; c++) begin
         @(negedge clk);
         if (grant != '0 && ng < 5) begin
            gs[ng] = grant;
            ng++;
            if (ng == 5) req = '0;
         end
         if (done) begin
            ds[nd] = done_id; eqs[nd] = eq; dc[nd] = c;
            nd++;
         end
      end
      req = '0;
      chk("rr_count", nd, 5);
      for (int k = 0; k < 5; k++) begin
         chk("rr_grant", gs[k], exp_g[k]);
         chk("rr_id", ds[k], k % N);
         chk("rr_eq", eqs[k], 1'b1);
         if (k > 0) chk("rr_spacing", dc[k] - dc[k-1], 3);
      end

      do_one(1, 16'h0000, 16'hFFFF, 1'b0, 3'b010);
      do_one(2, 16'hFFFF, 16'hFFFE, 1'b0, 3'b100);

      // Reset during EVAL: immediate return to reset values, no done.
      a_in[3*W +: W] = 16'hAAAA;
      b_in[3*W +: W] = 16'h5555;
      req = 4'b1000;
      ng = 0;
      do begin
         @(negedge clk);
         ng++;
      end while (grant == '0 && ng < 10);
      chk("mid_grant", grant, 4'b1000);
      req = '0;
      #2 n_rst = 1'b0;
      #1;
      chk("mid_rst_grant", grant, 4'b0000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_cmp_a", cmp_a, 16'h0000);
      chk("mid_rst_res", {gt, lt, eq, done_id}, 5'b00000);
      repeat (2) begin
         @(negedge clk);
         chk("mid_no_done", done, 1'b0);
      end
      #2 n_rst = 1'b1;
      do_one(3, 16'h0001, 16'h0002, 1'b0, 3'b010);

      // Inconsistent comparator answer, then a good compare.
      do_one(0, 16'h0005, 16'h0003, 1'b1, 3'b101);
      chk("err_set", err, ERR_EXP);
      do_one(1, 16'h0007, 16'h0007, 1'b0, 3'b001);
      chk("err_sticky", err, ERR_EXP);
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1 chk("err_rst", err, 1'b0);
      @(negedge clk);
      #2 n_rst = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
